// File: rtl/ext_bus_bridge.sv
// CPU-to-external byte bus bridge: multiplexes address latching, read and write
// strobes for an 8-bit external RAM/ROM bus behind a wider CPU word interface.
module ext_bus_bridge #(
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*ADDR_BYTES-1:0] address,
  input  logic                    read,
  input  logic                    write,
  input  logic [8*DATA_BYTES-1:0] dataIn,
  input  logic [2:0]              byteCount,
  output logic [8*DATA_BYTES-1:0] dataOut,
  output logic                    dataOutReady,
  output logic                    dataInReady,
  output logic [7:0]              io_out,
  output logic                    io_oe,
  input  logic [7:0]              io_in,
  output logic [ADDR_BYTES-1:0]   addr_latch,
  output logic                    ram_ce,
  output logic                    ram_rd,
  output logic                    ram_wr,
  output logic                    rom_ce,
  output logic                    rom_rd,
  output logic                    busy
);

  localparam int unsigned ADDR_W = 8 * ADDR_BYTES;
  localparam int unsigned DATA_W = 8 * DATA_BYTES;

  typedef logic [ADDR_BYTES-1:0][7:0] shadow_t;

  typedef enum logic [2:0] {
    IDLE, ADDR, RD_WAIT, RD_CAP, WR_STB, WR_HOLD, DONE
  } state_t;

  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input int unsigned k);
    return 8'(a >> (8 * k));
  endfunction

  function automatic int unsigned lowest_set(input logic [ADDR_BYTES-1:0] m);
    int unsigned r;
    r = 0;
    for (int unsigned j = ADDR_BYTES; j > 0; j--) begin
      if (m[j-1]) r = j - 1;
    end
    return r;
  endfunction

  function automatic logic [ADDR_BYTES-1:0] onehot(input int unsigned k);
    logic [ADDR_BYTES-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < ADDR_BYTES; j++) begin
      if (j == k) r[j] = 1'b1;
    end
    return r;
  endfunction

  // Address bytes that must be re-latched: all when the shadow is invalid.
  function automatic logic [ADDR_BYTES-1:0] diff_mask(input logic [ADDR_W-1:0] a,
                                                       input shadow_t sh, input logic vld);
    logic [ADDR_BYTES-1:0] r;
    for (int unsigned j = 0; j < ADDR_BYTES; j++) begin
      r[j] = !vld || (addr_byte(a, j) != sh[j]);
    end
    return r;
  endfunction

  state_t                r_state, n_state;
  logic                  r_armed, n_armed;
  logic                  r_is_read, n_is_read;
  logic                  r_is_rom, n_is_rom;
  logic [ADDR_W-1:0]     r_base, n_base;
  logic [2:0]            r_count, n_count;
  logic [2:0]            r_idx, n_idx;
  logic [DATA_W-1:0]     r_wdata, n_wdata;
  logic [DATA_W-1:0]     r_rdata, n_rdata;
  shadow_t               r_shadow, n_shadow;
  logic                  r_shadow_vld, n_shadow_vld;
  logic [ADDR_BYTES-1:0] r_mask, n_mask;
  logic [3:0]            r_cnt, n_cnt;

  logic [7:0]            r_io_out, n_io_out;
  logic                  r_io_oe, n_io_oe;
  logic [ADDR_BYTES-1:0] r_latch, n_latch;
  logic                  r_ram_ce, n_ram_ce;
  logic                  r_ram_rd, n_ram_rd;
  logic                  r_ram_wr, n_ram_wr;
  logic                  r_rom_ce, n_rom_ce;
  logic                  r_rom_rd, n_rom_rd;
  logic                  r_out_rdy, n_out_rdy;
  logic                  r_in_rdy, n_in_rdy;
  logic                  r_busy, n_busy;

  logic [2:0]            w_bc;
  int unsigned           w_k;
  int unsigned           w_nk;
  logic [ADDR_W-1:0]     w_cur;
  logic [ADDR_W-1:0]     w_next_addr;
  logic [ADDR_W-1:0]     w_n_addr;
  logic                  w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_armed      <= 1'b1;
      r_is_read    <= 1'b0;
      r_is_rom     <= 1'b0;
      r_base       <= '0;
      r_count      <= 3'd1;
      r_idx        <= 3'd0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_mask       <= '0;
      r_cnt        <= 4'd0;
      r_io_out     <= 8'd0;
      r_io_oe      <= 1'b0;
      r_latch      <= '0;
      r_ram_ce     <= 1'b0;
      r_ram_rd     <= 1'b0;
      r_ram_wr     <= 1'b0;
      r_rom_ce     <= 1'b0;
      r_rom_rd     <= 1'b0;
      r_out_rdy    <= 1'b0;
      r_in_rdy     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= n_state;
      r_armed      <= n_armed;
      r_is_read    <= n_is_read;
      r_is_rom     <= n_is_rom;
      r_base       <= n_base;
      r_count      <= n_count;
      r_idx        <= n_idx;
      r_wdata      <= n_wdata;
      r_rdata      <= n_rdata;
      r_shadow     <= n_shadow;
      r_shadow_vld <= n_shadow_vld;
      r_mask       <= n_mask;
      r_cnt        <= n_cnt;
      r_io_out     <= n_io_out;
      r_io_oe      <= n_io_oe;
      r_latch      <= n_latch;
      r_ram_ce     <= n_ram_ce;
      r_ram_rd     <= n_ram_rd;
      r_ram_wr     <= n_ram_wr;
      r_rom_ce     <= n_rom_ce;
      r_rom_rd     <= n_rom_rd;
      r_out_rdy    <= n_out_rdy;
      r_in_rdy     <= n_in_rdy;
      r_busy       <= n_busy;
    end
  end

  // Next state, then outputs derived from the next state so every output is a flop.
  always_comb begin
    n_state      = r_state;
    n_armed      = r_armed | (~read & ~write);
    n_is_read    = r_is_read;
    n_is_rom     = r_is_rom;
    n_base       = r_base;
    n_count      = r_count;
    n_idx        = r_idx;
    n_wdata      = r_wdata;
    n_rdata      = r_rdata;
    n_shadow     = r_shadow;
    n_shadow_vld = r_shadow_vld;
    n_mask       = r_mask;
    n_cnt        = r_cnt;

    w_bc = (byteCount == 3'd0) ? 3'd1 :
           (byteCount > 3'(DATA_BYTES)) ? 3'(DATA_BYTES) : byteCount;
    w_k         = lowest_set(r_mask);
    w_cur       = r_base + ADDR_W'(r_idx);
    w_next_addr = r_base + ADDR_W'(r_idx + 3'd1);
    w_last      = (r_idx == r_count - 3'd1);

    case (r_state)
      IDLE: begin
        if (r_armed && (read || write)) begin
          n_armed   = 1'b0;
          n_is_read = read;
          n_is_rom  = address[ADDR_W-1];
          n_base    = address;
          n_count   = w_bc;
          n_idx     = 3'd0;
          n_wdata   = dataIn;
          if (read) n_rdata = '0;
          if (!read && address[ADDR_W-1]) begin
            n_state = DONE;
          end else begin
            n_state = ADDR;
            n_mask  = '1;
          end
        end
      end
      ADDR: begin
        for (int unsigned j = 0; j < ADDR_BYTES; j++) begin
          if (j == w_k) n_shadow[j] = addr_byte(w_cur, j);
        end
        n_shadow_vld = 1'b1;
        n_mask       = r_mask & ~onehot(w_k);
        if (n_mask == '0) begin
          if (r_is_read) begin
            if (WAIT_CYCLES == 0) begin
              n_state = RD_CAP;
            end else begin
              n_state = RD_WAIT;
              n_cnt   = 4'(WAIT_CYCLES - 1);
            end
          end else begin
            n_state = WR_STB;
            n_cnt   = 4'(WAIT_CYCLES);
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == 4'd0) n_state = RD_CAP;
        else               n_cnt   = r_cnt - 4'd1;
      end
      WR_STB: begin
        if (r_cnt == 4'd0) n_state = WR_HOLD;
        else               n_cnt   = r_cnt - 4'd1;
      end
      RD_CAP, WR_HOLD: begin
        if (r_state == RD_CAP) begin
          for (int unsigned j = 0; j < DATA_BYTES; j++) begin
            if (j == 32'(r_idx)) n_rdata[8*j +: 8] = io_in;
          end
        end
        if (w_last) begin
          n_state = DONE;
        end else begin
          n_idx   = r_idx + 3'd1;
          n_mask  = diff_mask(w_next_addr, n_shadow, n_shadow_vld);
          n_state = ADDR;
        end
      end
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase

    n_io_out  = 8'd0;
    n_io_oe   = 1'b0;
    n_latch   = '0;
    n_ram_ce  = 1'b0;
    n_ram_rd  = 1'b0;
    n_ram_wr  = 1'b0;
    n_rom_ce  = 1'b0;
    n_rom_rd  = 1'b0;
    n_out_rdy = 1'b0;
    n_in_rdy  = 1'b0;
    n_busy    = (n_state != IDLE);
    w_n_addr  = n_base + ADDR_W'(n_idx);
    w_nk      = lowest_set(n_mask);

    case (n_state)
      ADDR: begin
        n_latch  = onehot(w_nk);
        n_io_out = addr_byte(w_n_addr, w_nk);
        n_io_oe  = 1'b1;
      end
      RD_WAIT, RD_CAP: begin
        n_rom_ce = n_is_rom;
        n_rom_rd = n_is_rom;
        n_ram_ce = !n_is_rom;
        n_ram_rd = !n_is_rom;
      end
      WR_STB, WR_HOLD: begin
        n_io_out = 8'(n_wdata >> {n_idx, 3'b000});
        n_io_oe  = 1'b1;
        n_ram_ce = 1'b1;
        n_ram_wr = (n_state == WR_STB);
      end
      DONE: begin
        n_out_rdy = n_is_read;
        n_in_rdy  = !n_is_read;
      end
      default: ;
    endcase
  end

  assign dataOut      = r_rdata;
  assign dataOutReady = r_out_rdy;
  assign dataInReady  = r_in_rdy;
  assign io_out       = r_io_out;
  assign io_oe        = r_io_oe;
  assign addr_latch   = r_latch;
  assign ram_ce       = r_ram_ce;
  assign ram_rd       = r_ram_rd;
  assign ram_wr       = r_ram_wr;
  assign rom_ce       = r_rom_ce;
  assign rom_rd       = r_rom_rd;
  assign busy         = r_busy;

endmodule
